// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the 16-bit control core.
package core_pkg;
    localparam int INSTR_W = 16;
    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT_SYN, WAIT_MEM, HALTED} seq_state_t;
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_BP   = 4'h8;
    localparam logic [3:0] OP_SYN  = 4'h9;
    localparam logic [3:0] OP_LDE  = 4'hA;
    localparam logic [3:0] OP_STE  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;
endpackage

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/issue controller walking the pc through imem,
// stalling on decoder syn / memory-op flags until the matching ack.
module instr_sequencer
    import core_pkg::*;
#(
    parameter int PC_W = 10,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               imem_rd_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               dec_halt,
    input  logic               dec_branch,
    input  logic               dec_syn,
    input  logic               dec_mem_op,
    input  logic               bp_cond,
    input  logic               sync_ack,
    input  logic               mem_ack,
    output logic               busy,
    output logic               halted
);
    seq_state_t state, state_nx;
    logic [PC_W-1:0] pc, pc_nx, pc_inc;

    assign pc_inc = pc + PC_W'(1);

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        case (state)
            IDLE, HALTED: if (start) begin
                state_nx = FETCH;
                pc_nx    = RESET_PC;
            end
            FETCH: state_nx = ISSUE;
            ISSUE: begin
                if (dec_halt) state_nx = HALTED;
                else if (dec_branch) begin
                    state_nx = FETCH;
                    pc_nx    = bp_cond ? instr[PC_W-1:0] : pc_inc;
                end
                else if (dec_syn) state_nx = WAIT_SYN;
                else if (dec_mem_op) state_nx = WAIT_MEM;
                else begin
                    state_nx = FETCH;
                    pc_nx    = pc_inc;
                end
            end
            WAIT_SYN: if (sync_ack) begin
                state_nx = FETCH;
                pc_nx    = pc_inc;
            end
            WAIT_MEM: if (mem_ack) begin
                state_nx = FETCH;
                pc_nx    = pc_inc;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= RESET_PC;
            instr <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            if (state == FETCH) instr <= imem_rdata;
        end
    end

    assign imem_rd_en  = state == FETCH;
    assign imem_addr   = pc;
    assign instr_valid = state == ISSUE;
    assign busy        = state inside {FETCH, ISSUE, WAIT_SYN, WAIT_MEM};
    assign halted      = state == HALTED;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed tests for instr_sequencer with a behavioural imem and decoder.
module tb_instr_sequencer;
    import core_pkg::*;

    logic clk = 0;
    logic rst_n, start, bp_cond, sync_ack, mem_ack;
    logic imem_rd_en, instr_valid, busy, halted;
    logic [9:0] imem_addr;
    logic [15:0] imem_rdata, instr;
    logic dec_halt, dec_branch, dec_syn, dec_mem_op;
    logic [15:0] mem [0:1023];

    logic start4, rd_en4, valid4, busy4, halted4;
    logic [3:0] addr4;
    logic [15:0] rdata4, instr4;
    logic [15:0] mem4 [0:15];

    int total = 0, bad = 0;

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr];
    assign dec_halt   = instr[15:12] == OP_HALT;
    assign dec_branch = instr[15:12] == OP_BP;
    assign dec_syn    = instr[15:12] == OP_SYN;
    assign dec_mem_op = instr[15:12] == OP_LDE || instr[15:12] == OP_STE;
    assign rdata4     = mem4[addr4];

    instr_sequencer #(.PC_W(10), .RESET_PC(10'd0)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .imem_rd_en(imem_rd_en),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .instr(instr),
        .instr_valid(instr_valid), .dec_halt(dec_halt), .dec_branch(dec_branch),
        .dec_syn(dec_syn), .dec_mem_op(dec_mem_op), .bp_cond(bp_cond),
        .sync_ack(sync_ack), .mem_ack(mem_ack), .busy(busy), .halted(halted)
    );

    instr_sequencer #(.PC_W(4), .RESET_PC(4'd14)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .imem_rd_en(rd_en4),
        .imem_addr(addr4), .imem_rdata(rdata4), .instr(instr4),
        .instr_valid(valid4), .dec_halt(instr4[15:12] == OP_HALT), .dec_branch(1'b0),
        .dec_syn(1'b0), .dec_mem_op(1'b0), .bp_cond(1'b0),
        .sync_ack(1'b0), .mem_ack(1'b0), .busy(busy4), .halted(halted4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic wait_issue(input logic [15:0] w, output bit ok);
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            tick();
            if (instr_valid && instr == w) ok = 1;
        end
    endtask

    task automatic wait_halt(output bit ok);
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            tick();
            if (halted) ok = 1;
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        #2;
        total++;
        if ({imem_rd_en, instr_valid, busy, halted} !== 4'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b want=0000", {imem_rd_en, instr_valid, busy, halted});
        end
        total++;
        if (instr !== 16'h0 || imem_addr !== 10'd0) begin
            bad++;
            $display("FAIL reset_regs instr=%h addr=%h want 0000/000", instr, imem_addr);
        end
        tick();
        tick();
        rst_n = 1;
        tick();
        total++;
        if (busy !== 1'b0 || halted !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset busy=%b halted=%b want 0/0", busy, halted);
        end
    endtask

    task automatic test_straight_line();
        logic [15:0] vmask;
        logic [9:0] addrs [$];
        clear_mem();
        mem[2] = 16'hF000;
        vmask = '0;
        pulse_start();
        for (int c = 1; c <= 8; c++) begin
            if (instr_valid) vmask[c] = 1'b1;
            if (imem_rd_en) addrs.push_back(imem_addr);
            if (c < 8) tick();
        end
        total++;
        if (vmask !== 16'h0054) begin
            bad++;
            $display("FAIL straight_valid_cycles got=%h want=0054", vmask);
        end
        total++;
        if (addrs.size() != 3 || addrs[0] !== 10'd0 || addrs[1] !== 10'd1 || addrs[2] !== 10'd2) begin
            bad++;
            $display("FAIL straight_addrs got n=%0d want 0,1,2", addrs.size());
        end
        total++;
        if (halted !== 1'b1 || busy !== 1'b0 || instr !== 16'hF000) begin
            bad++;
            $display("FAIL straight_halted halted=%b busy=%b instr=%h want 1/0/F000", halted, busy, instr);
        end
    endtask

    task automatic test_branch();
        bit ok;
        clear_mem();
        mem[5] = 16'h8010;
        mem[6] = 16'hF000;
        mem[16] = 16'hF000;
        for (int t = 0; t < 2; t++) begin
            bp_cond = (t == 0);
            pulse_start();
            wait_issue(16'h8010, ok);
            tick();
            total++;
            if (!ok || imem_rd_en !== 1'b1 || imem_addr !== (t == 0 ? 10'h010 : 10'd6)) begin
                bad++;
                $display("FAIL branch_target bp=%b ok=%b rd=%b addr=%h want %h", bp_cond, ok, imem_rd_en,
                         imem_addr, (t == 0 ? 10'h010 : 10'd6));
            end
            wait_halt(ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL branch_halt timeout halted=%b want 1", halted);
            end
        end
        bp_cond = 0;
    endtask

    task automatic test_syn();
        bit ok;
        int n;
        clear_mem();
        mem[3] = 16'h9000;
        mem[4] = 16'hF000;
        for (int t = 0; t < 2; t++) begin
            pulse_start();
            wait_issue(16'h9000, ok);
            if (t == 1) sync_ack = 1;
            tick();
            n = 0;
            for (int i = 0; i < 30 && !imem_rd_en; i++) begin
                if (busy && !instr_valid) n++;
                if (n == 7) sync_ack = 1;
                tick();
            end
            sync_ack = 0;
            total++;
            if (!ok || n != (t == 0 ? 7 : 1) || imem_addr !== 10'd4) begin
                bad++;
                $display("FAIL syn_wait ok=%b cycles=%0d addr=%h want %0d/004", ok, n, imem_addr, (t == 0 ? 7 : 1));
            end
            wait_halt(ok);
        end
    endtask

    task automatic test_mem_stall();
        bit ok;
        int stay;
        clear_mem();
        mem[2] = 16'hB000;
        mem[3] = 16'hF000;
        pulse_start();
        wait_issue(16'hB000, ok);
        mem_ack = 1;
        tick();
        mem_ack = 0;
        stay = 0;
        for (int i = 0; i < 5; i++) begin
            if (busy && !imem_rd_en && !instr_valid) stay++;
            tick();
        end
        total++;
        if (!ok || stay != 5) begin
            bad++;
            $display("FAIL mem_ack_ignored ok=%b stall_cycles=%0d want 5", ok, stay);
        end
        mem_ack = 1;
        tick();
        mem_ack = 0;
        total++;
        if (imem_rd_en !== 1'b1 || imem_addr !== 10'd3) begin
            bad++;
            $display("FAIL mem_advance rd=%b addr=%h want 1/003", imem_rd_en, imem_addr);
        end
        wait_halt(ok);
    endtask

    task automatic test_wrap();
        logic [3:0] a [$];
        for (int i = 0; i < 16; i++) mem4[i] = 16'h0000;
        mem4[2] = 16'hF000;
        start4 = 1;
        tick();
        start4 = 0;
        for (int i = 0; i < 12; i++) begin
            if (rd_en4) a.push_back(addr4);
            tick();
        end
        total++;
        if (a.size() != 5 || a[0] !== 4'd14 || a[1] !== 4'd15 || a[2] !== 4'd0 || a[3] !== 4'd1) begin
            bad++;
            $display("FAIL pc_wrap n=%0d want 5 fetches 14,15,0,1,2", a.size());
        end
        total++;
        if (halted4 !== 1'b1) begin
            bad++;
            $display("FAIL wrap_halt halted=%b want 1", halted4);
        end
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        clear_mem();
        mem[1] = 16'hA000;
        mem[2] = 16'hF000;
        pulse_start();
        wait_issue(16'hA000, ok);
        tick();
        tick();
        mem_ack = 1;
        rst_n = 0;
        #1;
        total++;
        if (!ok || {imem_rd_en, instr_valid, busy, halted} !== 4'b0 || instr !== 16'h0 || imem_addr !== 10'd0) begin
            bad++;
            $display("FAIL reset_mid_wait ok=%b flags=%b instr=%h addr=%h want 0000/0000/000", ok,
                     {imem_rd_en, instr_valid, busy, halted}, instr, imem_addr);
        end
        mem_ack = 0;
        tick();
        rst_n = 1;
        tick();
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL no_pending_ack busy=%b want 0", busy);
        end
        pulse_start();
        total++;
        if (imem_rd_en !== 1'b1 || imem_addr !== 10'd0) begin
            bad++;
            $display("FAIL restart_fetch rd=%b addr=%h want 1/000", imem_rd_en, imem_addr);
        end
        tick();
        start = 1;
        tick();
        start = 0;
        total++;
        if (imem_rd_en !== 1'b1 || imem_addr !== 10'd1) begin
            bad++;
            $display("FAIL start_in_issue rd=%b addr=%h want 1/001", imem_rd_en, imem_addr);
        end
        tick();
        tick();
        start = 1;
        tick();
        start = 0;
        total++;
        if (busy !== 1'b1 || imem_rd_en !== 1'b0 || instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL start_in_wait busy=%b rd=%b valid=%b want 1/0/0", busy, imem_rd_en, instr_valid);
        end
        mem_ack = 1;
        tick();
        mem_ack = 0;
        total++;
        if (imem_addr !== 10'd2) begin
            bad++;
            $display("FAIL resume_after_wait addr=%h want 002", imem_addr);
        end
        wait_halt(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL final_halt timeout halted=%b want 1", halted);
        end
    endtask

    initial begin
        rst_n = 0;
        start = 0;
        start4 = 0;
        bp_cond = 0;
        sync_ack = 0;
        mem_ack = 0;
        clear_mem();
        for (int i = 0; i < 16; i++) mem4[i] = 16'h0000;
        test_reset();
        test_straight_line();
        test_branch();
        test_syn();
        test_mem_stall();
        test_wrap();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
